spi_slave_responder: RTL
========================

# spi_slave_responder

Synthesizable SPI slave that answers the SPI master core on the pad side: it consumes `ss_pad_o[n]`, `sclk_pad_o` and `mosi_pad_o`, and drives `miso_pad_i`. All pad inputs are oversampled and synchronized into the system clock domain. Received characters are delivered as parallel words. Transmit characters are taken from a one-deep holding register. It serves as the RTL bus-functional slave in system benches and as a synthesizable peripheral front end. Framing, bit order and edge selection mirror the master's `char_len` / `lsb` / `tx_neg` / `rx_neg` controls.

## Interface
- `MAX_LEN`, 32: maximum character length in bits; also the data width.
- `CLW`, `$clog2(MAX_LEN)`: width of `cfg_char_len`.
- `wb_clk_i` in 1: single system clock. All logic runs on its rising edge.
- `wb_rst_i` in 1: asynchronous, active-high reset.
- `ss_n_i` in 1: slave select from one `ss_pad_o` bit, active low.
- `sclk_i` in 1: SPI clock from the master. It is asynchronous to `wb_clk_i` and idles low.
- `mosi_i` in 1: serial data from the master.
- `miso_o` out 1: serial data to the master. Forced to 0 when the block is deselected.
- `miso_oe_o` out 1: pad output enable. Equals 1 while selected.
- `cfg_char_len` in CLW: bits per character. 0 means MAX_LEN.
- `cfg_lsb` in 1: 1 = LSB first; 0 = bit `len-1` first.
- `cfg_tx_neg` in 1: 1 = master changes MOSI on negedge.
- `cfg_rx_neg` in 1: 1 = master samples MISO on negedge.
- `tx_data_i` in MAX_LEN: next transmit word.
- `tx_valid_i` in 1: transmit word valid.
- `tx_ready_o` out 1: holding register empty.
- `rx_data_o` out MAX_LEN: last received word, right-aligned, with unused upper bits 0.
- `rx_valid_o` out 1: one-cycle pulse when a character completes.
- `tx_underrun_o` out 1: one-cycle pulse when a character starts with no held word.
- `abort_o` out 1: one-cycle pulse when SS deasserts mid-character.
- `busy_o` out 1: 1 while selected.

## Operation
- **Synchronization.** `ss_n_i`, `sclk_i` and `mosi_i` each pass through 2-flop synchronizers. A third register on sclk provides edge detection.
  - rise = `s2 & ~s3`; fall = `~s2 & s3`.
- **Edge roles.**
  - MOSI sample edge is the edge opposite `cfg_tx_neg`: rise if `tx_neg=1`, else fall.
  - MISO drive edge is the edge opposite `cfg_rx_neg`.
  - MISO master-sample edge is the `cfg_rx_neg` edge.
- **Configuration capture.** Config inputs are captured on the synchronized SS falling edge. Changes while selected are ignored.
- **FSM.**
  - IDLE: SS high.
  - IDLE→SHIFT on synchronized SS low. On entry:
    - load the tx shift register from holding and mark holding empty; if holding is empty, load 0 and pulse `tx_underrun_o`;
    - clear the rx shift register, bit counters and the `adv_ok` flag;
    - `miso_o` presents bit 0 of the character (per `lsb`).
  - SHIFT→IDLE on synchronized SS high.
- **Receive.**
  - Each sample edge shifts `mosi` into the rx register and increments `rx_cnt`.
  - When `rx_cnt` reaches `len`: `rx_data_o` <= word, pulse `rx_valid_o`, and `rx_cnt` <= 0.
  - SS stays low across characters; back-to-back characters are supported.
- **Transmit.**
  - A master-sample edge sets `adv_ok`.
  - A drive edge with `adv_ok=1` advances to the next bit and clears `adv_ok`.
  - A drive edge with `adv_ok=0` is ignored. This protects bit 0 when the drive edge is the first edge.
  - On an advance past bit `len-1`: load the next character from holding (or 0 with `tx_underrun_o`) and present its bit 0.
- **Holding register.** `tx_valid_i & tx_ready_o` loads the word. `tx_ready_o = ~hold_full`. A load and a consume in the same cycle: the consume takes the old word and the new word is stored.
- **Deselect mid-character** (`rx_cnt != 0` or transmit index != 0):
  - pulse `abort_o`;
  - discard the partial rx data; `rx_valid_o` does not fire;
  - the tx shift register is cleared; the holding register is kept.
- **Simultaneous events.** SS rising in the same cycle as a sample edge: the edge is ignored and deselect takes priority.

## Timing
- **Reset values.**
  - `miso_o=0`, `miso_oe_o=0`, `rx_data_o=0`, `rx_valid_o=0`, `tx_underrun_o=0`, `abort_o=0`, `busy_o=0`.
  - `tx_ready_o=1`. FSM is in IDLE.
- **Latency.**
  - A pad edge is registered internally 3 `wb_clk` cycles later.
  - `rx_valid_o` and `miso_o` update in that same cycle (3 cycles after the pad edge).
  - `busy_o`/`miso_oe_o` rise 3 cycles after SS falls and fall 3 cycles after SS rises.
- **SCLK limit.** SCLK high and low phases must each be ≥4 `wb_clk_i` periods, and SS setup to the first edge must be ≥4 periods. Narrower pulses are out of spec.
- **Reset mid-transfer.** Returns immediately to reset values. The block resumes at the next SS fall.

## Test plan
- Mode `tx_neg=1`, `rx_neg=0`, `len=8`, MSB first; hold `0xA5`; master sends `0x3C` → MISO bits `1,0,1,0,0,1,0,1`; `rx_data_o=0x3C` with a single `rx_valid_o` pulse.
- `tx_neg=0`, `rx_neg=1`, `lsb=1`, `len=16`, hold `0x8001` → master receives `0x8001` (bit 0 not lost); master sends `0x1234` → `rx_data_o=0x00001234`.
- Two 8-bit characters with SS held low; hold `0x11`, then load `0x22` mid-character → `rx_valid_o` pulses twice; MISO returns `0x11` then `0x22`; `tx_underrun_o` never pulses.
- SS falls with the holding register empty → `tx_underrun_o` pulses once; master reads `0x00`; `tx_ready_o` stays 1.
- SS rises after 5 of 8 bits → `abort_o` pulses once; `rx_valid_o` stays 0; `miso_oe_o=0`; the next transfer restarts at bit 0.
- Assert `wb_rst_i` asynchronously mid-character → all outputs take reset values within the same cycle; `tx_ready_o=1`; a subsequent transfer completes normally.

Source files
------------

// File: rtl/spi_slave_responder.sv
// SPI slave front end: oversamples the master's pad signals in the system clock
// domain, returns parallel rx words and serializes tx words from a one-deep holding register.
module spi_slave_responder #(
    parameter int MAX_LEN = 32,
    parameter int CLW     = $clog2(MAX_LEN)
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               ss_n_i,
    input  logic               sclk_i,
    input  logic               mosi_i,
    output logic               miso_o,
    output logic               miso_oe_o,
    input  logic [CLW-1:0]     cfg_char_len,
    input  logic               cfg_lsb,
    input  logic               cfg_tx_neg,
    input  logic               cfg_rx_neg,
    input  logic [MAX_LEN-1:0] tx_data_i,
    input  logic               tx_valid_i,
    output logic               tx_ready_o,
    output logic [MAX_LEN-1:0] rx_data_o,
    output logic               rx_valid_o,
    output logic               tx_underrun_o,
    output logic               abort_o,
    output logic               busy_o
);

    localparam int CW = CLW + 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t state_reg, state_next;

    logic [1:0] ss_sync_reg;
    logic [2:0] sclk_sync_reg;
    logic [1:0] mosi_sync_reg;

    logic [CLW-1:0]     len_reg;
    logic               lsb_reg, tx_neg_reg, rx_neg_reg;
    logic [MAX_LEN-1:0] hold_data_reg, tx_word_reg, rx_shift_reg, rx_data_reg;
    logic               hold_full_reg, adv_ok_reg;
    logic [CW-1:0]      rx_cnt_reg;
    logic [CLW-1:0]     tx_idx_reg;
    logic               rx_valid_reg, underrun_reg, abort_reg;

    logic               ss_s, sclk_s2, sclk_s3, mosi_s;
    logic               sclk_rise, sclk_fall, active;
    logic               sample_edge, ms_edge, drive_edge;
    logic               enter, leave, advance, wrap, consume, hold_load, partial;
    logic [CW-1:0]      len_eff, rx_cnt_inc;
    logic               rx_done, tx_last;
    logic [CLW-1:0]     tx_pos;
    logic [MAX_LEN-1:0] rx_lsb_word, rx_shift_in;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ss_sync_reg   <= 2'b11;
            sclk_sync_reg <= '0;
            mosi_sync_reg <= '0;
        end else begin
            ss_sync_reg   <= {ss_sync_reg[0], ss_n_i};
            sclk_sync_reg <= {sclk_sync_reg[1:0], sclk_i};
            mosi_sync_reg <= {mosi_sync_reg[0], mosi_i};
        end
    end

    assign ss_s      = ss_sync_reg[1];
    assign sclk_s2   = sclk_sync_reg[1];
    assign sclk_s3   = sclk_sync_reg[2];
    assign mosi_s    = mosi_sync_reg[1];
    assign sclk_rise = sclk_s2 & ~sclk_s3;
    assign sclk_fall = ~sclk_s2 & sclk_s3;

    // Edges only count while selected; a deselect in the same cycle wins.
    assign active      = (state_reg == SHIFT) && !ss_s;
    assign sample_edge = active && (tx_neg_reg ? sclk_rise : sclk_fall);
    assign ms_edge     = active && (rx_neg_reg ? sclk_fall : sclk_rise);
    assign drive_edge  = active && (rx_neg_reg ? sclk_rise : sclk_fall);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        enter      = 1'b0;
        leave      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!ss_s) begin
                    state_next = SHIFT;
                    enter      = 1'b1;
                end
            end
            SHIFT: begin
                if (ss_s) begin
                    state_next = IDLE;
                    leave      = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign len_eff    = (len_reg == '0) ? CW'(MAX_LEN) : {1'b0, len_reg};
    assign rx_cnt_inc = rx_cnt_reg + CW'(1);
    assign rx_done    = (rx_cnt_inc == len_eff);
    assign tx_last    = ({1'b0, tx_idx_reg} == len_eff - CW'(1));
    assign advance    = drive_edge && adv_ok_reg;
    assign wrap       = advance && tx_last;
    assign consume    = enter || wrap;
    assign hold_load  = tx_valid_i && !hold_full_reg;

    // Last bit already presented and sampled by the master counts as a finished character.
    assign partial = (rx_cnt_reg != '0) ||
                     ((tx_idx_reg != '0) && !(tx_last && adv_ok_reg));

    generate
        for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_rx_lsb
            assign rx_lsb_word[gi] = rx_shift_reg[gi] | (mosi_s & (rx_cnt_reg == CW'(gi)));
        end
    endgenerate

    assign rx_shift_in = lsb_reg ? rx_lsb_word : {rx_shift_reg[MAX_LEN-2:0], mosi_s};

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            len_reg       <= '0;
            lsb_reg       <= 1'b0;
            tx_neg_reg    <= 1'b0;
            rx_neg_reg    <= 1'b0;
            hold_data_reg <= '0;
            hold_full_reg <= 1'b0;
            tx_word_reg   <= '0;
            tx_idx_reg    <= '0;
            adv_ok_reg    <= 1'b0;
            rx_shift_reg  <= '0;
            rx_cnt_reg    <= '0;
            rx_data_reg   <= '0;
            rx_valid_reg  <= 1'b0;
            underrun_reg  <= 1'b0;
            abort_reg     <= 1'b0;
        end else begin
            rx_valid_reg <= 1'b0;
            underrun_reg <= 1'b0;
            abort_reg    <= 1'b0;

            // Consume reads the old word even when a new one is stored this cycle.
            if (hold_load) hold_data_reg <= tx_data_i;
            hold_full_reg <= (hold_full_reg && !consume) || hold_load;
            if (consume) begin
                tx_word_reg  <= hold_full_reg ? hold_data_reg : '0;
                underrun_reg <= !hold_full_reg;
            end

            if (enter) begin
                len_reg      <= cfg_char_len;
                lsb_reg      <= cfg_lsb;
                tx_neg_reg   <= cfg_tx_neg;
                rx_neg_reg   <= cfg_rx_neg;
                rx_shift_reg <= '0;
                rx_cnt_reg   <= '0;
                tx_idx_reg   <= '0;
                adv_ok_reg   <= 1'b0;
            end else if (leave) begin
                abort_reg    <= partial;
                rx_shift_reg <= '0;
                rx_cnt_reg   <= '0;
                tx_idx_reg   <= '0;
                adv_ok_reg   <= 1'b0;
                tx_word_reg  <= '0;
            end else begin
                if (sample_edge) begin
                    if (rx_done) begin
                        rx_data_reg  <= rx_shift_in;
                        rx_valid_reg <= 1'b1;
                        rx_shift_reg <= '0;
                        rx_cnt_reg   <= '0;
                    end else begin
                        rx_shift_reg <= rx_shift_in;
                        rx_cnt_reg   <= rx_cnt_inc;
                    end
                end
                if (advance) begin
                    adv_ok_reg <= 1'b0;
                    tx_idx_reg <= tx_last ? '0 : tx_idx_reg + CLW'(1);
                end else if (ms_edge) begin
                    adv_ok_reg <= 1'b1;
                end
            end
        end
    end

    assign tx_pos = lsb_reg ? tx_idx_reg
                            : CLW'(len_eff - CW'(1) - {1'b0, tx_idx_reg});

    assign busy_o        = (state_reg == SHIFT);
    assign miso_oe_o     = busy_o;
    assign miso_o        = busy_o & tx_word_reg[tx_pos];
    assign tx_ready_o    = ~hold_full_reg;
    assign rx_data_o     = rx_data_reg;
    assign rx_valid_o    = rx_valid_reg;
    assign tx_underrun_o = underrun_reg;
    assign abort_o       = abort_reg;

endmodule
